// File: rtl/demux_dest_n.sv
// demux_dest_n: routes each input word by its top DEST_BITS into one of NUM_DEST FIFOs.
// Latency: 1 cycle from accept to valid_out/data_out, no bypass into an empty FIFO.
// Backpressure: ready_out drops only while the addressed FIFO is full; pause flags at AFULL.
// Optional: define DEMUX_DEST_DROP_COUNT_EN to add a saturating drop_cnt port.
module demux_dest_n #(
  parameter int BITNUMBER = 5,
  parameter int NUM_DEST  = 4,
  parameter int DEST_BITS = 2,
  parameter int PTR_BITS  = 2,
  parameter int AFULL     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [BITNUMBER-1:0]          data_in,
  output logic                          ready_out,
  output logic [NUM_DEST-1:0]           valid_out,
  output logic [NUM_DEST*BITNUMBER-1:0] data_out,
  input  logic [NUM_DEST-1:0]           ready_in,
  output logic [NUM_DEST-1:0]           pause
`ifdef DEMUX_DEST_DROP_COUNT_EN
  ,
  output logic [7:0]                    drop_cnt
`endif
);

  localparam int DEPTH = 2 ** PTR_BITS;
  localparam logic [PTR_BITS:0]  DEPTH_C    = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS:0]  AFULL_C    = (PTR_BITS+1)'(AFULL);
  localparam logic [DEST_BITS:0] NUM_DEST_C = (DEST_BITS+1)'(NUM_DEST);

  logic [DEST_BITS-1:0] dest;
  logic                 dest_ok;
  logic                 accept;

  logic [NUM_DEST-1:0]  full;
  logic [NUM_DEST-1:0]  sel;
  logic [NUM_DEST-1:0]  push;
  logic [NUM_DEST-1:0]  pop;

  logic [PTR_BITS-1:0]  wr_ptr     [NUM_DEST];
  logic [PTR_BITS-1:0]  rd_ptr     [NUM_DEST];
  logic [PTR_BITS-1:0]  wr_ptr_nxt [NUM_DEST];
  logic [PTR_BITS-1:0]  rd_ptr_nxt [NUM_DEST];
  logic [PTR_BITS:0]    count      [NUM_DEST];
  logic [PTR_BITS:0]    count_nxt  [NUM_DEST];

  logic [BITNUMBER-1:0] mem      [NUM_DEST][DEPTH];
  logic [BITNUMBER-1:0] head_q   [NUM_DEST];
  logic [BITNUMBER-1:0] head_nxt [NUM_DEST];

  assign dest    = data_in[BITNUMBER-1 -: DEST_BITS];
  assign dest_ok = ({1'b0, dest} < NUM_DEST_C);

  // Decode destination, derive handshake, and compute post-edge FIFO state
  always_comb begin
    full      = '0;
    sel       = '0;
    valid_out = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      full[i]      = (count[i] == DEPTH_C);
      sel[i]       = (dest == DEST_BITS'(i));
      valid_out[i] = (count[i] != '0);
    end
    // Invalid destinations are always accepted so they can be discarded
    ready_out = !(valid_in && dest_ok && |(sel & full));
    accept    = valid_in && ready_out;
    push      = {NUM_DEST{accept && dest_ok}} & sel;
    pop       = valid_out & ready_in;
    for (int i = 0; i < NUM_DEST; i++) begin
      wr_ptr_nxt[i] = push[i] ? wr_ptr[i] + 1'b1 : wr_ptr[i];
      rd_ptr_nxt[i] = pop[i]  ? rd_ptr[i] + 1'b1 : rd_ptr[i];
      case ({push[i], pop[i]})
        2'b10:   count_nxt[i] = count[i] + 1'b1;
        2'b01:   count_nxt[i] = count[i] - 1'b1;
        default: count_nxt[i] = count[i];
      endcase
      // The incoming word becomes the new head when it lands on the next read slot
      if (count_nxt[i] == '0)
        head_nxt[i] = '0;
      else if (push[i] && (wr_ptr[i] == rd_ptr_nxt[i]))
        head_nxt[i] = data_in;
      else
        head_nxt[i] = mem[i][rd_ptr_nxt[i]];
    end
  end

  // Pointer, occupancy, registered head and pause state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        head_q[i] <= '0;
      end
      pause <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        wr_ptr[i] <= wr_ptr_nxt[i];
        rd_ptr[i] <= rd_ptr_nxt[i];
        count[i]  <= count_nxt[i];
        head_q[i] <= head_nxt[i];
        pause[i]  <= (count_nxt[i] >= AFULL_C);
      end
    end
  end

  // Storage array; writes suppressed on the reset edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DEST; i++) begin
      if (push[i] && !reset)
        mem[i][wr_ptr[i]] <= data_in;
    end
  end

  // Pack per-destination heads onto the flat output bus
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_DEST; i++)
      data_out[i*BITNUMBER +: BITNUMBER] = head_q[i];
  end

`ifdef DEMUX_DEST_DROP_COUNT_EN
  // Saturating count of accepted words whose destination does not exist
  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (accept && !dest_ok && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_demux_dest_n.sv
// Scoreboard bench for demux_dest_n: 4-way main instance plus a 3-way instance
// for invalid-destination handling. Expected words are queued per destination
// at acceptance and popped by an independent monitor on each output handshake.
module tb_demux_dest_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [4:0]  data_in;
  logic        ready_out;
  logic [3:0]  valid_out;
  logic [19:0] data_out;
  logic [3:0]  ready_in;
  logic [3:0]  pause;

  logic        valid_in3;
  logic [4:0]  data_in3;
  logic        ready_out3;
  logic [2:0]  valid_out3;
  logic [14:0] data_out3;
  logic [2:0]  ready_in3;
  logic [2:0]  pause3;
`ifdef DEMUX_DEST_DROP_COUNT_EN
  logic [7:0]  drop_cnt;
  logic [7:0]  drop_cnt3;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q [4][$];

  always #5 clk = ~clk;

  demux_dest_n #(.BITNUMBER(5), .NUM_DEST(4), .DEST_BITS(2), .PTR_BITS(2), .AFULL(3)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .ready_in(ready_in), .pause(pause)
`ifdef DEMUX_DEST_DROP_COUNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  demux_dest_n #(.BITNUMBER(5), .NUM_DEST(3), .DEST_BITS(2), .PTR_BITS(2), .AFULL(3)) dut3 (
    .clk(clk), .reset(reset), .valid_in(valid_in3), .data_in(data_in3),
    .ready_out(ready_out3), .valid_out(valid_out3), .data_out(data_out3),
    .ready_in(ready_in3), .pause(pause3)
`ifdef DEMUX_DEST_DROP_COUNT_EN
    , .drop_cnt(drop_cnt3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for acceptance, and record its expectation
  task automatic push_word(input logic [4:0] w);
    valid_in = 1'b1;
    data_in  = w;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ready_out) begin
        exp_q[w[4:3]].push_back(w);
        step();
        valid_in = 1'b0;
        return;
      end
      step();
    end
    errors++;
    $display("FAIL push_timeout: word %0h never accepted", w);
    valid_in = 1'b0;
  endtask

  // Monitor: every output handshake must deliver the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin
          if (valid_out[i] && ready_in[i]) begin
            if (exp_q[i].size() == 0) begin
              chk($sformatf("unexpected_pop%0d", i), {27'd0, data_out[i*5 +: 5]}, 32'hFFFF_FFFF);
            end else begin
              chk($sformatf("pop_data%0d", i), {27'd0, data_out[i*5 +: 5]}, {27'd0, exp_q[i].pop_front()});
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = '0;
    valid_in3 = 1'b0; data_in3 = '0; ready_in3 = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid_out", {28'd0, valid_out}, 32'h0);
    chk("rst_pause", {28'd0, pause}, 32'h0);
    chk("rst_data_out", {12'd0, data_out}, 32'h0);
    chk("rst_ready_out", {31'd0, ready_out}, 32'h1);
    step();

    // Single word to dest 2, one-cycle latency
    valid_in = 1'b1; data_in = 5'b10_101;
    @(negedge clk);
    chk("t1_ready", {31'd0, ready_out}, 32'h1);
    exp_q[2].push_back(5'h15);
    step();
    valid_in = 1'b0;
    @(negedge clk);
    chk("t1_valid_out", {28'd0, valid_out}, 32'h4);
    chk("t1_data_out", {12'd0, data_out}, 32'h5400);
    chk("t1_pause", {28'd0, pause}, 32'h0);
    step();
    ready_in = 4'b0100;
    step();
    ready_in = 4'b0000;
    @(negedge clk);
    chk("t1_drained", {28'd0, valid_out}, 32'h0);
    step();

    // Fill dest 1, pause threshold, full backpressure, other dest unblocked
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1; data_in = 5'h08 + 5'(k);
      @(negedge clk);
      chk($sformatf("t2_pause_before_push%0d", k), {31'd0, pause[1]}, {31'd0, (k >= 3)});
      chk($sformatf("t2_ready%0d", k), {31'd0, ready_out}, 32'h1);
      exp_q[1].push_back(5'h08 + 5'(k));
      step();
    end
    data_in = 5'h0C;
    @(negedge clk);
    chk("t2_pause_full", {31'd0, pause[1]}, 32'h1);
    chk("t2_valid_out", {28'd0, valid_out}, 32'h2);
    chk("t2_ready_full", {31'd0, ready_out}, 32'h0);
    step();
    data_in = 5'h00;
    @(negedge clk);
    chk("t2_ready_other", {31'd0, ready_out}, 32'h1);
    exp_q[0].push_back(5'h00);
    step();

    // Drain dest 1 while the held word waits for space
    data_in = 5'h0C; ready_in = 4'b0010;
    @(negedge clk);
    chk("t3_no_passthru", {31'd0, ready_out}, 32'h0);
    step();
    @(negedge clk);
    chk("t3_ready_after_pop", {31'd0, ready_out}, 32'h1);
    exp_q[1].push_back(5'h0C);
    step();
    valid_in = 1'b0;
    step(); step(); step();
    ready_in = 4'b0000;
    @(negedge clk);
    chk("t3_v1_empty", {31'd0, valid_out[1]}, 32'h0);
    chk("t3_slice1_zero", {27'd0, data_out[9:5]}, 32'h0);
    chk("t3_pause1_clear", {31'd0, pause[1]}, 32'h0);
    step();

    // Dest 0 at 2 words, simultaneous push/pop across pointer wrap
    push_word(5'h01);
    for (int j = 0; j < 6; j++) begin
      valid_in = 1'b1; data_in = 5'h02 + 5'(j); ready_in = 4'b0001;
      @(negedge clk);
      chk($sformatf("t4_ready%0d", j), {31'd0, ready_out}, 32'h1);
      chk($sformatf("t4_pause%0d", j), {31'd0, pause[0]}, 32'h0);
      chk($sformatf("t4_valid%0d", j), {31'd0, valid_out[0]}, 32'h1);
      exp_q[0].push_back(5'h02 + 5'(j));
      step();
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("t4_pause_after", {31'd0, pause[0]}, 32'h0);
    step();
    step();
    ready_in = 4'b0000;
    @(negedge clk);
    chk("t4_empty", {28'd0, valid_out}, 32'h0);
    step();

    // Invalid destination on the 3-way instance
    for (int k = 0; k < 3; k++) begin
      valid_in3 = 1'b1; data_in3 = 5'b11_000;
      @(negedge clk);
      chk($sformatf("t5_ready%0d", k), {31'd0, ready_out3}, 32'h1);
      step();
    end
    valid_in3 = 1'b0;
    @(negedge clk);
    chk("t5_valid_out3", {29'd0, valid_out3}, 32'h0);
    chk("t5_data_out3", {17'd0, data_out3}, 32'h0);
`ifdef DEMUX_DEST_DROP_COUNT_EN
    chk("t5_drop_cnt3", {24'd0, drop_cnt3}, 32'd3);
    chk("t5_drop_cnt_main", {24'd0, drop_cnt}, 32'd0);
`endif
    step();

    // Reset mid-operation discards buffered words and the concurrent push
    push_word(5'h03);
    push_word(5'h04);
    push_word(5'h12);
    @(negedge clk);
    chk("t6_pre_valid", {28'd0, valid_out}, 32'h5);
    chk("t6_pre_data", {12'd0, data_out}, 32'h4803);
    step();
    reset = 1'b1; valid_in = 1'b1; data_in = 5'h11;
    step();
    reset = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(negedge clk);
    chk("t6_valid_out", {28'd0, valid_out}, 32'h0);
    chk("t6_pause", {28'd0, pause}, 32'h0);
    chk("t6_data_out", {12'd0, data_out}, 32'h0);
    chk("t6_ready_out", {31'd0, ready_out}, 32'h1);
`ifdef DEMUX_DEST_DROP_COUNT_EN
    chk("t6_drop_cnt3", {24'd0, drop_cnt3}, 32'd0);
`endif
    step();
    @(negedge clk);
    chk("t6_not_stored", {28'd0, valid_out}, 32'h0);
    step();

    for (int i = 0; i < 4; i++)
      chk($sformatf("end_queue%0d", i), exp_q[i].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
